// File: rtl/store_order_gate.sv
// store_order_gate: orders non-idempotent loads behind all outstanding dcache stores
// and caps the number of unacknowledged stores.
module store_order_gate #(
  parameter int MaxOutstandingStores = 7,
  parameter int CntWidth = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  output logic                st_valid_o,
  input  logic                st_ready_i,
  input  logic                st_ack_i,
  input  logic                ld_valid_i,
  input  logic                ld_nonidem_i,
  output logic                ld_ready_o,
  output logic                ld_valid_o,
  input  logic                ld_ready_i,
  output logic [CntWidth-1:0] outstanding_cnt_o,
  output logic                no_st_pending_o,
  output logic                err_o
);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, ISSUE = 2'd2;
  logic [1:0] r_state, w_next;
  logic [CntWidth-1:0] r_cnt;
  logic r_err;
  logic w_nonidem, w_zero, w_full, w_st_en, w_ld_en, w_st_hs;
  assign w_nonidem = ld_valid_i & ld_nonidem_i;
  assign w_zero = r_cnt == '0;
  assign w_full = r_cnt == CntWidth'(MaxOutstandingStores);
  // Reset gates both enables so no request leaks out while rst_ni is low.
  always_comb begin
    w_st_en = rst_ni & (r_state == IDLE) & ~w_full & ~w_nonidem;
    w_ld_en = rst_ni & ~flush_i & ((r_state == ISSUE) | ((r_state == IDLE) & (~w_nonidem | w_zero)));
    w_next = flush_i ? IDLE :
             (r_state == IDLE)  ? (w_nonidem ? (~w_zero ? DRAIN : (ld_ready_i ? IDLE : ISSUE)) : IDLE) :
             (r_state == DRAIN) ? ((w_zero | ((r_cnt == CntWidth'(1)) & st_ack_i)) ? ISSUE : DRAIN) :
             ((~ld_valid_i | ld_ready_i) ? IDLE : ISSUE);
  end
  assign st_valid_o = st_valid_i & w_st_en;
  assign st_ready_o = st_ready_i & w_st_en;
  assign ld_valid_o = ld_valid_i & w_ld_en;
  assign ld_ready_o = ld_ready_i & w_ld_en;
  assign w_st_hs = st_valid_o & st_ready_i;
  assign outstanding_cnt_o = r_cnt;
  assign no_st_pending_o = w_zero;
  assign err_o = r_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_st_hs & ~st_ack_i) r_cnt <= r_cnt + CntWidth'(1);
      else if (st_ack_i & ~w_st_hs & ~w_zero) r_cnt <= r_cnt - CntWidth'(1);
      if (st_ack_i & ~w_st_hs & w_zero) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_store_order_gate.sv
// tb_store_order_gate: directed vectors with hand-computed expectations.
module tb_store_order_gate;
  logic clk = 0, rst_n = 0, flush = 0, st_valid = 0, st_ready = 0, st_ack = 0;
  logic ld_valid = 0, ld_nonidem = 0, ld_ready = 0;
  logic st_ready_o, st_valid_o, ld_ready_o, ld_valid_o, no_st_pending, err;
  logic [2:0] cnt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  store_order_gate dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .st_valid_i(st_valid), .st_ready_o(st_ready_o), .st_valid_o(st_valid_o),
    .st_ready_i(st_ready), .st_ack_i(st_ack),
    .ld_valid_i(ld_valid), .ld_nonidem_i(ld_nonidem), .ld_ready_o(ld_ready_o),
    .ld_valid_o(ld_valid_o), .ld_ready_i(ld_ready),
    .outstanding_cnt_o(cnt), .no_st_pending_o(no_st_pending), .err_o(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic acks(input int n);
    st_ack = 1;
    repeat (n) step();
    st_ack = 0;
  endtask
  task automatic stores(input int n);
    st_valid = 1;
    st_ready = 1;
    repeat (n) step();
    st_valid = 0;
  endtask
  initial begin
    st_valid = 1; st_ready = 1; ld_valid = 1; ld_ready = 1; st_ack = 1;
    #12;
    chk("rst_st_valid", st_valid_o, 0);
    chk("rst_ld_valid", ld_valid_o, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_nopend", no_st_pending, 1);
    chk("rst_err", err, 0);
    st_valid = 0; st_ack = 0; ld_valid = 0; ld_ready = 0;
    @(negedge clk) rst_n = 1;
    step();
    // saturation
    st_valid = 1; st_ready = 1;
    for (int i = 0; i < 7; i++) begin
      #1 chk("sat_ready", st_ready_o, 1);
      step();
    end
    chk("sat_cnt7", cnt, 7);
    chk("sat_block", st_ready_o, 0);
    chk("sat_block_v", st_valid_o, 0);
    step();
    chk("sat_hold7", cnt, 7);
    st_ack = 1;
    #1 chk("sat_ack_nobypass", st_ready_o, 0);
    step();
    st_ack = 0;
    chk("sat_cnt6", cnt, 6);
    chk("sat_8th_ready", st_ready_o, 1);
    step();
    st_valid = 0;
    chk("sat_8th_cnt", cnt, 7);
    acks(7);
    chk("drain_cnt0", cnt, 0);
    chk("drain_nopend", no_st_pending, 1);
    // simultaneous store and ack
    stores(2);
    chk("sim_cnt2", cnt, 2);
    st_valid = 1; st_ack = 1;
    step();
    st_valid = 0; st_ack = 0;
    chk("sim_hold2", cnt, 2);
    acks(2);
    // non-idempotent load beats a same-cycle store at count 0
    ld_valid = 1; ld_nonidem = 1; ld_ready = 1; st_valid = 1;
    #1;
    chk("ni0_ld_valid", ld_valid_o, 1);
    chk("ni0_ld_ready", ld_ready_o, 1);
    chk("ni0_st_ready", st_ready_o, 0);
    chk("ni0_st_valid", st_valid_o, 0);
    step();
    st_valid = 0;
    chk("ni0_cnt", cnt, 0);
    chk("ni0_idle_ld", ld_valid_o, 1);
    ld_valid = 0;
    // ordering
    stores(3);
    chk("ord_cnt3", cnt, 3);
    ld_valid = 1; ld_nonidem = 1; ld_ready = 1;
    #1 chk("ord_idle_block", ld_valid_o, 0);
    step();
    st_valid = 1;
    #1;
    chk("ord_drain_ld", ld_valid_o, 0);
    chk("ord_drain_st", st_ready_o, 0);
    st_ack = 1;
    step();
    chk("ord_ack1_ld", ld_valid_o, 0);
    step();
    chk("ord_ack2_ld", ld_valid_o, 0);
    chk("ord_ack2_st", st_ready_o, 0);
    step();
    st_ack = 0;
    chk("ord_issue_ld", ld_valid_o, 1);
    chk("ord_issue_st", st_ready_o, 0);
    chk("ord_cnt0", cnt, 0);
    step();
    ld_valid = 0;
    #1 chk("ord_idle_st", st_ready_o, 1);
    st_valid = 0;
    // ISSUE abandoned when the load drops
    ld_valid = 1; ld_ready = 0;
    step();
    st_valid = 1;
    #1 chk("iss_st_blocked", st_valid_o, 0);
    chk("iss_ld_valid", ld_valid_o, 1);
    ld_valid = 0;
    step();
    chk("iss_back_idle", st_valid_o, 1);
    st_valid = 0;
    #1;
    // error on ack with count 0
    st_ack = 1;
    step();
    st_ack = 0;
    chk("err_cnt0", cnt, 0);
    chk("err_set", err, 1);
    // flush in DRAIN
    stores(2);
    ld_valid = 1; ld_nonidem = 1; ld_ready = 1;
    step();
    flush = 1;
    #1 chk("fl_no_ld", ld_valid_o, 0);
    step();
    flush = 0; ld_valid = 0;
    chk("fl_cnt2", cnt, 2);
    st_valid = 1;
    #1 chk("fl_idle", st_ready_o, 1);
    st_valid = 0;
    acks(2);
    chk("fl_acks_cnt0", cnt, 0);
    chk("err_sticky", err, 1);
    // reset mid-DRAIN with count 4
    stores(4);
    ld_valid = 1; ld_nonidem = 1; ld_ready = 1;
    step();
    chk("rd_cnt4", cnt, 4);
    st_valid = 1; st_ready = 1;
    #2 rst_n = 0;
    #1;
    chk("rd_cnt0", cnt, 0);
    chk("rd_st_valid", st_valid_o, 0);
    chk("rd_ld_valid", ld_valid_o, 0);
    chk("rd_nopend", no_st_pending, 1);
    chk("rd_err_clr", err, 0);
    st_valid = 0;
    @(negedge clk) rst_n = 1;
    #1 chk("rd_idle_ld", ld_valid_o, 1);
    // reset mid-ISSUE
    ld_ready = 0;
    step();
    #2 rst_n = 0;
    #1 chk("ri_ld_valid", ld_valid_o, 0);
    ld_valid = 0;
    @(negedge clk) rst_n = 1;
    st_valid = 1;
    #1 chk("ri_idle_st", st_valid_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
